// File: rtl/vend_dispense_ctrl.sv
// rtl/vend_dispense_ctrl.sv - vending credit keeper and dispense sequencer
// Consumes one-cycle buy/coin/return pulses; all outputs are registered.
module vend_dispense_ctrl #(
    parameter int BAL_W       = 16,
    parameter int PRICE0      = 500,
    parameter int PRICE1      = 1000,
    parameter int PRICE2      = 1500,
    parameter int PRICE3      = 2000,
    parameter int MAX_BAL     = 9900,
    parameter int DISP_CYCLES = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       buy_pulse,
    input  logic             coin100_pulse,
    input  logic             coin500_pulse,
    input  logic             return_pulse,
    output logic [BAL_W-1:0] balance,
    output logic [3:0]       dispense,
    output logic             busy,
    output logic             err_insufficient,
    output logic             coin_reject,
    output logic             change_valid,
    output logic [BAL_W-1:0] change_amount
);

    localparam int CNT_W = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;

    typedef enum logic {
        S_IDLE,
        S_DISPENSE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    logic [BAL_W-1:0] w_coin_sum;
    logic [3:0]       w_slot_oh;
    logic [BAL_W-1:0] w_price;
    logic             w_idle;
    logic             w_refund;
    logic             w_buy_req;
    logic             w_afford;
    logic             w_buy_ok;
    logic             w_buy_err;
    logic [BAL_W-1:0] w_base;
    logic [BAL_W:0]   w_coin_total;
    logic             w_coin_rej;

    always_comb begin
        w_coin_sum = '0;
        if (coin100_pulse) w_coin_sum = w_coin_sum + BAL_W'(100);
        if (coin500_pulse) w_coin_sum = w_coin_sum + BAL_W'(500);
    end

    // Lowest set request bit wins; the remaining bits are dropped.
    always_comb begin
        w_slot_oh = 4'b0000;
        w_price   = BAL_W'(PRICE0);
        if (buy_pulse[0]) begin
            w_slot_oh = 4'b0001;
            w_price   = BAL_W'(PRICE0);
        end else if (buy_pulse[1]) begin
            w_slot_oh = 4'b0010;
            w_price   = BAL_W'(PRICE1);
        end else if (buy_pulse[2]) begin
            w_slot_oh = 4'b0100;
            w_price   = BAL_W'(PRICE2);
        end else if (buy_pulse[3]) begin
            w_slot_oh = 4'b1000;
            w_price   = BAL_W'(PRICE3);
        end
    end

    assign w_idle    = (r_state == S_IDLE);
    assign w_refund  = w_idle && return_pulse;
    assign w_buy_req = w_idle && !return_pulse && (buy_pulse != 4'b0000);
    assign w_afford  = (balance >= w_price);
    assign w_buy_ok  = w_buy_req && w_afford;
    assign w_buy_err = w_buy_req && !w_afford;

    // Price is checked against the pre-coin balance; coins land after the debit.
    assign w_base       = w_buy_ok ? (balance - w_price) : balance;
    assign w_coin_total = {1'b0, w_base} + {1'b0, w_coin_sum};
    assign w_coin_rej   = (w_coin_sum != '0) && (w_coin_total > (BAL_W+1)'(MAX_BAL));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= S_IDLE;
            r_cnt            <= '0;
            balance          <= '0;
            dispense         <= 4'b0000;
            busy             <= 1'b0;
            err_insufficient <= 1'b0;
            coin_reject      <= 1'b0;
            change_valid     <= 1'b0;
            change_amount    <= '0;
        end else begin
            err_insufficient <= 1'b0;
            coin_reject      <= 1'b0;
            change_valid     <= 1'b0;
            change_amount    <= '0;

            // A refund pays out same-cycle coins too, so they are never rejected.
            if (w_refund) begin
                change_valid  <= 1'b1;
                change_amount <= balance + w_coin_sum;
                balance       <= '0;
            end else begin
                balance          <= w_coin_rej ? w_base : w_coin_total[BAL_W-1:0];
                coin_reject      <= w_coin_rej;
                err_insufficient <= w_buy_err;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_buy_ok) begin
                        dispense <= w_slot_oh;
                        busy     <= 1'b1;
                        r_cnt    <= CNT_W'(DISP_CYCLES - 1);
                        r_state  <= S_DISPENSE;
                    end
                end
                S_DISPENSE: begin
                    if (r_cnt == '0) begin
                        dispense <= 4'b0000;
                        busy     <= 1'b0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    dispense <= 4'b0000;
                    busy     <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/vend_dispense_ctrl.md
Name: vend_dispense_ctrl

Overview:
Consumer side of the one-cycle buy/coin pulse interface. It accepts registered 1-clk pulses (buy_pulse[3:0], coin pulses, return pulse), keeps the customer credit balance, and decides each purchase against per-slot prices. On success it drives a held dispense strobe for the selected slot; on a refund request it issues the change. It sits between the pulse generators and the display/actuator logic of the vending machine.

Parameters:
BAL_W, 16, width of balance and price values
PRICE0, 500, price of slot 0
PRICE1, 1000, price of slot 1
PRICE2, 1500, price of slot 2
PRICE3, 2000, price of slot 3
MAX_BAL, 9900, largest balance accepted; must be < 2^BAL_W
DISP_CYCLES, 8, cycles dispense[i] stays high (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
buy_pulse  input  4  one-cycle purchase request per slot
coin100_pulse  input  1  one-cycle 100-unit coin insert
coin500_pulse  input  1  one-cycle 500-unit coin insert
return_pulse  input  1  one-cycle refund request
balance  output  BAL_W  current credit, registered
dispense  output  4  one-hot, held DISP_CYCLES cycles
busy  output  1  high while in DISPENSE
err_insufficient  output  1  one-cycle pulse: buy rejected for low credit
coin_reject  output  1  one-cycle pulse: coin rejected (would exceed MAX_BAL)
change_valid  output  1  one-cycle pulse: refund issued
change_amount  output  BAL_W  refund value, valid with change_valid, else 0

Behaviour:
- Reset (async, reset_n=0): state IDLE; balance=0, dispense=0, busy=0, all pulses 0, change_amount=0, dispense counter 0. Reset mid-DISPENSE aborts immediately; no pending action survives.
- All outputs registered; response appears on the first rising edge after the input pulse is sampled (1-cycle latency).
- States: IDLE, DISPENSE.
- IDLE, per cycle, priority return > buy:
  - return_pulse: change_valid=1, change_amount=balance+coin_sum (same-cycle coins refunded, never rejected), balance->0. Any buy_pulse that cycle ignored.
  - else buy_pulse!=0: slot i = lowest set bit (other bits dropped). If balance >= PRICEi: balance -> balance-PRICEi, dispense=one-hot(i), busy=1, counter=DISP_CYCLES-1, go DISPENSE. Else err_insufficient=1, balance unchanged, stay IDLE.
- Price compare uses pre-coin balance; same-cycle coins are added after subtraction.
- coin_sum = 100*coin100_pulse + 500*coin500_pulse (both same cycle: 600, treated as one add). Accepted in both states. If result (after any subtraction) > MAX_BAL: entire coin_sum rejected, coin_reject=1, balance excludes it. Balance never exceeds MAX_BAL, never underflows.
- DISPENSE: dispense and busy held; counter decrements each cycle; when counter==0 and clocked, dispense=0, busy=0, go IDLE. buy_pulse and return_pulse ignored (not queued, no error pulse). dispense high exactly DISP_CYCLES cycles.
- err_insufficient, coin_reject, change_valid are single-cycle and clear the next cycle unless retriggered; change_amount returns to 0 with change_valid.
- dispense is always zero or one-hot; busy==(dispense!=0).

Test Plan:
- Reset then coin500 x2 -> balance 500 then 1000; buy_pulse=0010 -> next cycle dispense=0010, busy=1, balance=0; dispense high exactly 8 cycles, then IDLE.
- Balance 400, buy_pulse=0001 -> err_insufficient one cycle, balance stays 400, dispense=0.
- Balance 9800, coin500 -> coin_reject=1, balance 9800; coin100 -> balance 9900; further coin100 -> coin_reject.
- Balance 2000, buy_pulse=1110 -> slot1 chosen, dispense=0010, balance 1000; buy_pulse during DISPENSE -> ignored, balance stays 1000.
- Balance 700, return_pulse with coin100 same cycle -> change_valid=1, change_amount=800, balance 0; return concurrent with buy -> no dispense.
- Balance 1500, buy slot2 + coin500 same cycle -> dispense=0100, balance 500; reset_n low at DISPENSE cycle 3 -> dispense/busy/balance 0 immediately.
